// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps one bus request outstanding,
// buffers up to two fetched words and applies delay-slot-aware redirects from ID.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        id_stall_i,
    input  logic        do_branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        jump_flag_i,
    input  logic        jr_flag_i,
    input  logic [31:0] jr_target_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc4_o,
    output logic        if_adel_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    typedef struct packed {
        logic        adel;
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t      state, state_nx;
    logic [31:0] pc_q, bd_target, addr_q, out_pc4;
    logic        bd_pending, discard, halted, req_q, out_valid, hold_valid;
    entry_t      out_e, hold_e, new_e, out_src;

    logic        consume, misaligned, accept, fill, make_adel, new_valid;
    logic        load_out, load_hold, clear_out, redirect;
    logic [31:0] pc_post, target, jump_target;

    assign consume    = out_valid && !id_stall_i;
    assign misaligned = pc_q[1:0] != 2'b00;
    assign accept     = (state == REQ) && inst_addr_ok_i;
    assign fill       = (state == WAIT) && inst_data_ok_i && !discard;
    assign make_adel  = (state == IDLE) && misaligned && !hold_valid && !halted;
    assign new_valid  = fill || make_adel;

    // Redirects compare against the PC as it will be after this edge's accept.
    assign pc_post     = (accept && !discard) ? (bd_pending ? bd_target : pc_q + 32'd4) : pc_q;
    assign jump_target = {out_pc4[31:28], out_e.instr[25:0], 2'b00};
    assign target      = jr_flag_i ? jr_target_i : (jump_flag_i ? jump_target : branch_addr_i);
    assign redirect    = consume && (jr_flag_i || jump_flag_i || do_branch_i);

    always_comb begin
        new_e.adel  = !fill;
        new_e.pc    = fill ? addr_q : pc_q;
        new_e.instr = fill ? inst_rdata_i : '0;
    end

    always_comb begin
        load_out  = 1'b0;
        load_hold = 1'b0;
        clear_out = 1'b0;
        out_src   = new_e;
        if (consume) begin
            if (hold_valid) begin
                load_out  = 1'b1;
                out_src   = hold_e;
                load_hold = new_valid;
            end else if (new_valid) begin
                load_out = 1'b1;
            end else begin
                clear_out = 1'b1;
            end
        end else if (new_valid) begin
            load_out  = !out_valid;
            load_hold = out_valid;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!hold_valid && !misaligned && !flush_i) state_nx = REQ;
            REQ:     if (inst_addr_ok_i) state_nx = WAIT;
            WAIT:    if (inst_data_ok_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= '0;
            bd_pending <= 1'b0;
            bd_target  <= '0;
            discard    <= 1'b0;
            halted     <= 1'b0;
            out_valid  <= 1'b0;
            out_e      <= '0;
            out_pc4    <= '0;
            hold_valid <= 1'b0;
            hold_e     <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx == REQ) begin
                req_q  <= 1'b1;
                addr_q <= pc_q;
            end else if (accept) begin
                req_q <= 1'b0;
            end

            if (flush_i) begin
                pc_q       <= flush_pc_i;
                bd_pending <= 1'b0;
                halted     <= 1'b0;
                out_valid  <= 1'b0;
                out_e.adel <= 1'b0;
                hold_valid <= 1'b0;
                discard    <= (state == REQ) || (state == WAIT && !inst_data_ok_i);
            end else begin
                pc_q <= pc_post;
                if (accept && !discard) bd_pending <= 1'b0;
                if (redirect) begin
                    if (pc_post == out_e.pc + 32'd8) begin
                        pc_q <= target;
                    end else if (pc_post == out_e.pc + 32'd4) begin
                        bd_pending <= 1'b1;
                        bd_target  <= target;
                    end
                end
                if (state == WAIT && inst_data_ok_i) discard <= 1'b0;
                if (make_adel) halted <= 1'b1;

                if (load_out) begin
                    out_e     <= out_src;
                    out_pc4   <= out_src.pc + 32'd4;
                    out_valid <= 1'b1;
                end else if (clear_out) begin
                    out_valid  <= 1'b0;
                    out_e.adel <= 1'b0;
                end

                if (load_hold) begin
                    hold_e     <= new_e;
                    hold_valid <= 1'b1;
                end else if (consume) begin
                    hold_valid <= 1'b0;
                end
            end
        end
    end

    assign inst_req_o  = req_q;
    assign inst_addr_o = addr_q;
    assign id_valid_o  = out_valid;
    assign id_instr_o  = out_e.instr;
    assign id_pc_o     = out_e.pc;
    assign id_pc4_o    = out_pc4;
    assign if_adel_o   = out_e.adel;
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage feeding the decode stage. Owns the fetch PC and issues one SRAM-like instruction request at a time. Presents fetched instructions and their PC+4 to decode, and applies branch, jump and jr redirects from decode after the MIPS delay slot. Sits between the instruction-side bus bridge and ID; exception/eret flushes arrive from the CP0/commit logic.

## Interface
Parameters
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.

Ports
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- id_stall_i  in  1  ID holds its current instruction this cycle.
- do_branch_i  in  1  taken conditional branch in ID.
- branch_addr_i  in  32  branch target.
- jump_flag_i  in  1  j/jal in ID; target is {id_pc4_o[31:28], id_instr_o[25:0], 2'b00}, computed internally.
- jr_flag_i  in  1  jr/jalr in ID.
- jr_target_i  in  32  forwarded rs value.
- flush_i  in  1  exception/eret flush.
- flush_pc_i  in  32  new fetch PC on flush.
- inst_req_o  out  1  bus request.
- inst_addr_o  out  32  request address.
- inst_addr_ok_i  in  1  request accepted.
- inst_data_ok_i  in  1  read data valid.
- inst_rdata_i  in  32  instruction word.
- id_valid_o  out  1  id_instr_o holds a live instruction.
- id_instr_o  out  32  instruction to ID.
- id_pc_o  out  32  its PC.
- id_pc4_o  out  32  its PC+4.
- if_adel_o  out  1  misaligned-fetch exception tag for the instruction in ID.

## Operation
- Registers:
  - pc_q: next address to request.
  - Output register (id_*_o): one entry.
  - Hold buffer: one entry.
  - bd_pending / bd_target: delayed redirect.
  - discard: drop the next data_ok.
- FSM states: IDLE, REQ, WAIT.
  - IDLE→REQ when the hold buffer is empty.
  - REQ drives inst_req_o=1 and inst_addr_o=pc_q. Address and request are held stable until inst_addr_ok_i.
  - REQ→WAIT on addr_ok. At the same edge, pc_q advances to pc_q+4, or to bd_target if bd_pending, which also clears bd_pending.
  - WAIT→IDLE on data_ok.
- Misaligned pc_q (pc_q[1:0]≠0):
  - No bus request is issued.
  - An entry is produced directly with instr=0, if_adel_o=1, pc=pc_q.
  - pc_q does not advance until a flush.
- ID consumes when id_valid_o && !id_stall_i.
- On data_ok, the word goes to the output register if it is empty or being consumed this cycle; otherwise it goes to the hold buffer.
- The hold buffer drains to the output register on the next consume.
- There is never more than one request outstanding. This bounds pc_q to {id_pc_o+4, id_pc_o+8} whenever ID holds a valid instruction.
- Redirects are accepted only on consume. Target priority: jr_target_i, then the jump target, then branch_addr_i.
  - If pc_q==id_pc_o+8 (delay slot already requested), pc_q <= target.
  - If pc_q==id_pc_o+4, set bd_pending/bd_target so the delay slot is fetched first and pc_q jumps afterwards.
  - A redirect in the same cycle as a REQ addr_ok resolves against the post-edge pc_q.
- flush_i has highest priority:
  - pc_q <= flush_pc_i.
  - Output register, hold buffer and bd_pending are cleared.
  - If a request is in WAIT, or in REQ awaiting addr_ok, discard is set. The REQ is still held until addr_ok, and its data_ok is dropped, which clears discard.
  - The next request uses flush_pc_i.

## Timing
- Reset values:
  - inst_req_o=0, inst_addr_o=0.
  - id_valid_o=0, id_instr_o=0, id_pc_o=0, id_pc4_o=0, if_adel_o=0.
  - pc_q=RESET_PC, state IDLE.
  - Buffer, bd_pending and discard cleared.
- First inst_req_o is high in the second cycle after rst_i deasserts (IDLE→REQ).
- The bus returns data_ok no earlier than the cycle after addr_ok.
- id_valid_o rises the cycle after data_ok.
- With a zero-wait bus, throughput is one instruction per 3 cycles.
- flush_i takes effect at the next edge; id_valid_o is 0 in the following cycle.
- Asserting rst_i mid-request returns all state to reset values immediately. No pending data_ok is honoured afterwards; the bridge is reset together.

## Test plan
- Reset release, zero-wait bus returning 32'h2402_0001 at RESET_PC -> inst_addr_o=BFC0_0000, then BFC0_0004; id_instr_o=24020001, id_pc4_o=BFC0_0004.
- Taken beq at BFC0_0000 with target BFC0_0100, delay slot not yet requested -> fetch sequence BFC0_0000, BFC0_0004, BFC0_0100.
- Same branch, delay slot already in flight -> next request BFC0_0100; BFC0_0008 never requested.
- id_stall_i held 5 cycles while the delay slot returns -> slot lands in the hold buffer, no new inst_req_o; after release, slot then target delivered in order.
- flush_i with flush_pc_i=BFC0_0380 while in WAIT -> stale data_ok dropped, id_valid_o stays 0, next inst_addr_o=BFC0_0380.
- jr to 8000_0002 -> no bus request; id_valid_o=1, if_adel_o=1, id_pc_o=8000_0002, id_instr_o=0.
